// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: N-stage synchronizer, debounce filter and rise/fall strobes.
// Optional sticky edge flags when INPUT_CONDITIONER_EDGE_LATCH_EN is defined.
module input_conditioner #(
    parameter  int N_CH            = 8,
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] d_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            any_edge_o,
    output logic [N_CH-1:0] pending_o,
    input  logic [N_CH-1:0] ack_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
    logic [CNT_W-1:0]                 r_cnt [N_CH];
    logic [N_CH-1:0]                  r_level;
    logic [N_CH-1:0]                  r_rise;
    logic [N_CH-1:0]                  r_fall;
    logic                             r_any;

    logic [N_CH-1:0]                  w_s;
    logic [CNT_W-1:0]                 w_cnt_nxt [N_CH];
    logic [N_CH-1:0]                  w_level_nxt;
    logic [N_CH-1:0]                  w_rise_nxt;
    logic [N_CH-1:0]                  w_fall_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_level_nxt[i] = w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
        w_rise_nxt = w_level_nxt & ~r_level;
        w_fall_nxt = ~w_level_nxt & r_level;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_any   <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign level_o    = r_level;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign any_edge_o = r_any;

`ifdef INPUT_CONDITIONER_EDGE_LATCH_EN
    logic [N_CH-1:0] r_pending;

    // A strobe in the same cycle as an ack keeps the flag set.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_rise | r_fall) | (r_pending & ~ack_i);
        end
    end

    assign pending_o = r_pending;
`else
    logic w_unused_ack;
    assign w_unused_ack = ^ack_i;
    assign pending_o    = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized + directed bench for input_conditioner against a sample-window reference model.
// Honors INPUT_CONDITIONER_EDGE_LATCH_EN for the pending flag expectations.
module tb_input_conditioner;

    localparam int N = 8;
    localparam int S = 2;
    localparam int D = 16;
    localparam int H = S + D;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic [N-1:0] d_i = '0;
    logic [N-1:0] ack_i = '0;
    logic [N-1:0] level_o, rise_o, fall_o, pending_o;
    logic         any_edge_o;

    int checks = 0;
    int errors = 0;

    // Reference model: hist[k] is the d_i value captured k edges ago.
    logic [N-1:0] hist [H];
    logic [N-1:0] m_level, m_rise, m_fall, m_pend;
    logic         m_any;

    input_conditioner #(
        .N_CH            (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .d_i        (d_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .any_edge_o (any_edge_o),
        .pending_o  (pending_o),
        .ack_i      (ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < H; k++) hist[k] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_any = 1'b0;
    endtask

    // A channel's level flips once the D synchronized samples seen so far all differ from it.
    task automatic model_edge(input logic [N-1:0] d, input logic [N-1:0] a);
        logic [N-1:0] flip;
        bit           all_diff;
`ifdef INPUT_CONDITIONER_EDGE_LATCH_EN
        m_pend = (m_rise | m_fall) | (m_pend & ~a);
`else
        m_pend = '0;
`endif
        for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        flip = '0;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int m = S; m < H; m++) begin
                if (hist[m][c] == m_level[c]) all_diff = 1'b0;
            end
            flip[c] = all_diff;
        end
        m_rise  = flip & ~m_level;
        m_fall  = flip & m_level;
        m_level = m_level ^ flip;
        m_any   = |flip;
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ".level"}, 32'(level_o), 32'(m_level));
        chk({ph, ".rise"}, 32'(rise_o), 32'(m_rise));
        chk({ph, ".fall"}, 32'(fall_o), 32'(m_fall));
        chk({ph, ".any"}, 32'(any_edge_o), 32'(m_any));
        chk({ph, ".pend"}, 32'(pending_o), 32'(m_pend));
    endtask

    // Called at posedge+1; drives inputs, waits one active edge, then checks.
    task automatic step(input string ph, input logic [N-1:0] d, input logic [N-1:0] a);
        d_i = d;
        ack_i = a;
        @(posedge clk_i);
        model_edge(d, a);
        #1;
        compare_all(ph);
    endtask

    task automatic do_reset(input int cycles, input logic [N-1:0] d);
        reset_i = 1'b0;
        d_i = d;
        ack_i = '0;
        #1;
        model_clear();
        compare_all("rst_now");
        repeat (cycles) @(posedge clk_i);
        #1;
        compare_all("rst_hold");
        reset_i = 1'b1;
    endtask

    initial begin
        int first;
        logic [N-1:0] tgt;
        logic [N-1:0] a;

        model_clear();
        @(posedge clk_i);
        #1;
        do_reset(2, '0);

        for (int k = 0; k < 30; k++) step("idle", '0, '0);

        first = 0;
        for (int k = 1; k <= 30; k++) begin
            step("rise0", 8'h01, '0);
            if (level_o[0] && first == 0) first = k;
        end
        chk("rise0.latency", 32'(first), 32'(S + D));
        for (int k = 0; k < 30; k++) step("fall0", '0, '0);

        for (int k = 0; k < 10; k++) step("gl10", 8'h08, '0);
        for (int k = 0; k < 30; k++) step("gl10", '0, '0);
        for (int k = 0; k < 15; k++) step("gl15", 8'h08, '0);
        for (int k = 0; k < 30; k++) step("gl15", '0, '0);
        chk("gl15.level3", 32'(level_o[3]), 32'(0));
        for (int k = 0; k < 16; k++) step("gl16", 8'h08, '0);
        for (int k = 0; k < 40; k++) step("gl16", '0, '0);

        for (int k = 0; k < 25; k++) step("a5", 8'hA5, '0);
        chk("a5.level", 32'(level_o), 32'h A5);
        for (int k = 0; k < 25; k++) step("5a", 8'h5A, '0);
        for (int k = 0; k < 25; k++) step("zero", 8'h00, '0);

        for (int k = 0; k < 9; k++) step("mid", 8'h02, '0);
        do_reset(2, 8'h02);
        first = 0;
        for (int k = 1; k <= 25; k++) begin
            step("mid_rel", 8'h02, '0);
            if (level_o[1] && first == 0) first = k;
        end
        chk("mid.latency", 32'(first), 32'(S + D));
        for (int k = 0; k < 25; k++) step("mid_fall", '0, '0);

        for (int k = 0; k < 25; k++) step("pend_rise", 8'h04, '0);
        for (int k = 0; k < 3; k++) step("pend_hold", 8'h04, '0);
        step("pend_ack", 8'h04, 8'h04);
        step("pend_ack2", 8'h04, 8'h04);
        for (int k = 0; k < 25; k++) step("pend_fall_ack", 8'h00, 8'h04);
        for (int k = 0; k < 3; k++) step("pend_idle", 8'h00, '0);

        tgt = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 24) == 0) tgt[c] = ~tgt[c];
            end
            a = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3), tgt);
            else step("rand", tgt, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
